// File: rtl/eq_coe_sched_pkg.sv
// Shared constants for the equalizer coefficient-load path: band/gain sizing,
// biquad load-frame timing and ROM address field layout.
package eq_coe_sched_pkg;

   localparam int N_BAND   = 4;
   localparam int BAND_W   = 2;
   localparam int GAIN_W   = 5;
   localparam int COE_W    = 17;
   localparam int DEF_GAIN = 12;

   // Load frame: LEAD cycles of ROM prefetch, then NWORD coefficients;
   // the biquad expects NSTROBE strobes and GAP idle cycles to commit.
   localparam int LEAD      = 2;
   localparam int NWORD     = 6;
   localparam int NSTROBE   = 7;
   localparam int GAP       = 2;
   localparam int FRAME_LEN = LEAD + NWORD;

   // ROM address is {band, gain, word}
   localparam int WORD_W   = 3;
   localparam int WORD_LSB = 0;
   localparam int GAIN_LSB = WORD_LSB + WORD_W;
   localparam int BAND_LSB = GAIN_LSB + GAIN_W;
   localparam int ADDR_W   = BAND_LSB + BAND_W;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

endpackage

// File: rtl/eq_coe_sched_rr_arb.sv
// Round-robin pick: first pending band at or after the pointer, wrapping.
// Purely combinational; the pointer register lives in the parent.
module eq_rr_arb #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     pend_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_oh_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic             gnt_vld_o
);

   int               pos;
   logic [IDX_W-1:0] sel;

   always_comb begin
      gnt_oh_o  = '0;
      gnt_idx_o = '0;
      gnt_vld_o = 1'b0;
      pos       = 0;
      sel       = '0;
      for (int k = 0; k < N; k++) begin
         pos = int'(ptr_i) + k;
         if (pos >= N) pos = pos - N;
         sel = IDX_W'(pos);
         if (!gnt_vld_o && pend_i[sel]) begin
            gnt_vld_o      = 1'b1;
            gnt_oh_o[sel]  = 1'b1;
            gnt_idx_o      = sel;
         end
      end
   end

endmodule

// File: rtl/eq_coe_sched.sv
// Coefficient-update scheduler: queues per-band gain changes and streams each
// band's six ROM coefficients to its biquad as one strobed load frame.
module eq_coe_sched #(
   parameter int N_BAND   = eq_coe_sched_pkg::N_BAND,
   parameter int BAND_W   = eq_coe_sched_pkg::BAND_W,
   parameter int GAIN_W   = eq_coe_sched_pkg::GAIN_W,
   parameter int COE_W    = eq_coe_sched_pkg::COE_W,
   parameter int DEF_GAIN = eq_coe_sched_pkg::DEF_GAIN
) (
   input  logic                                            clk_40k,
   input  logic                                            rst,
   input  logic                                            req,
   input  logic [BAND_W-1:0]                               req_band,
   input  logic [GAIN_W-1:0]                               req_gain,
   input  logic                                            load_all,
   output logic [BAND_W+GAIN_W+eq_coe_sched_pkg::WORD_W-1:0] rom_addr,
   input  logic signed [COE_W-1:0]                         rom_rdata,
   output logic signed [COE_W-1:0]                         coe,
   output logic [N_BAND-1:0]                               coe_en,
   output logic                                            busy,
   output logic                                            done,
   output logic [BAND_W-1:0]                               done_band
);

   import eq_coe_sched_pkg::*;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BAND_W-1:0]  band_q, band_d;
   logic [GAIN_W-1:0]  gain_q, gain_d;
   logic [BAND_W-1:0]  rr_q, rr_d;
   logic [N_BAND-1:0]  pend_q, pend_d, pend_set;
   logic [GAIN_W-1:0]  gtab_q [N_BAND];
   logic [GAIN_W-1:0]  gtab_d [N_BAND];
   logic signed [COE_W-1:0] coe_q;

   logic [N_BAND-1:0]  gnt_oh;
   logic [BAND_W-1:0]  gnt_idx;
   logic               gnt_vld;
   logic               take;
   logic               coe_cap;

   // Request intake: later request overwrites the gain, req beats load_all
   always_comb begin
      pend_set = pend_q;
      gtab_d   = gtab_q;
      if (load_all) begin
         pend_set = '1;
         for (int b = 0; b < N_BAND; b++) gtab_d[b] = GAIN_W'(DEF_GAIN);
      end
      if (req) begin
         pend_set[req_band] = 1'b1;
         gtab_d[req_band]   = req_gain;
      end
   end

   eq_rr_arb #(
      .N     (N_BAND),
      .IDX_W (BAND_W)
   ) u_arb (
      .pend_i    (pend_set),
      .ptr_i     (rr_q),
      .gnt_oh_o  (gnt_oh),
      .gnt_idx_o (gnt_idx),
      .gnt_vld_o (gnt_vld)
   );

   // Next state: the last GAP cycle may grant directly, giving a 10-cycle pitch
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      take    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (gnt_vld) take = 1'b1;
         end
         ST_LOAD: begin
            if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
               state_d = ST_GAP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (cnt_q == CNT_W'(GAP - 1)) begin
               if (gnt_vld) begin
                  take = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      if (take) begin
         state_d = ST_LOAD;
         cnt_d   = '0;
      end
   end

   always_comb begin
      pend_d = take ? (pend_set & ~gnt_oh) : pend_set;
      band_d = take ? gnt_idx : band_q;
      gain_d = take ? gtab_d[gnt_idx] : gain_q;
      rr_d   = rr_q;
      if (take) rr_d = (gnt_idx == BAND_W'(N_BAND - 1)) ? '0 : gnt_idx + BAND_W'(1);
   end

   always_ff @(posedge clk_40k) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         band_q  <= '0;
         gain_q  <= '0;
         rr_q    <= '0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         band_q  <= band_d;
         gain_q  <= gain_d;
         rr_q    <= rr_d;
         pend_q  <= pend_d;
      end
   end

   always_ff @(posedge clk_40k) begin
      gtab_q <= gtab_d;
   end

   // ROM data for word f-1 is valid during frame cycle f; capture it for cycle f+1
   assign coe_cap = (state_q == ST_LOAD) &&
                    (cnt_q >= CNT_W'(LEAD - 1)) &&
                    (cnt_q <= CNT_W'(LEAD + NWORD - 2));

   always_ff @(posedge clk_40k) begin
      if (rst) begin
         coe_q <= '0;
      end else if (coe_cap) begin
         coe_q <= rom_rdata;
      end
   end

   always_comb begin
      coe_en    = '0;
      rom_addr  = '0;
      busy      = 1'b0;
      done      = 1'b0;
      done_band = '0;
      unique case (state_q)
         ST_LOAD: begin
            busy = 1'b1;
            if (cnt_q < CNT_W'(NSTROBE)) coe_en[band_q] = 1'b1;
            if (cnt_q < CNT_W'(NWORD))   rom_addr = {band_q, gain_q, cnt_q[WORD_W-1:0]};
         end
         ST_GAP: begin
            busy = 1'b1;
            if (cnt_q == '0) begin
               done      = 1'b1;
               done_band = band_q;
            end
         end
         default: ;
      endcase
   end

   assign coe = coe_q;

endmodule

// File: tb/tb_eq_coe_sched.sv
// Scoreboarded bench for eq_coe_sched with a 1-cycle ROM model and a
// behavioural biquad load port on band 0.
module tb_eq_coe_sched;

   logic               clk_40k = 1'b0;
   logic               rst = 1'b1;
   logic               req = 1'b0;
   logic [1:0]         req_band = '0;
   logic [4:0]         req_gain = '0;
   logic               load_all = 1'b0;
   logic [9:0]         rom_addr;
   logic signed [16:0] rom_rdata = '0;
   logic signed [16:0] coe;
   logic [3:0]         coe_en;
   logic               busy;
   logic               done;
   logic [1:0]         done_band;

   eq_coe_sched dut (
      .clk_40k   (clk_40k),
      .rst       (rst),
      .req       (req),
      .req_band  (req_band),
      .req_gain  (req_gain),
      .load_all  (load_all),
      .rom_addr  (rom_addr),
      .rom_rdata (rom_rdata),
      .coe       (coe),
      .coe_en    (coe_en),
      .busy      (busy),
      .done      (done),
      .done_band (done_band)
   );

   always #5 clk_40k = ~clk_40k;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk_40k) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic signed [16:0] bq_val(input int w);
      case (w)
         0: return 17'sd32768;
         1: return -17'sd58935;
         2: return 17'sd30050;
         3: return 17'sd32768;
         4: return -17'sd58935;
         default: return 17'sd30050;
      endcase
   endfunction

   // Band 0 gain 31 holds the biquad-in-loop test set; all else is a distinct ramp
   function automatic logic signed [16:0] rom_word(input logic [9:0] a);
      if (a[9:8] == 2'd0 && a[7:3] == 5'd31 && a[2:0] < 3'd6) return bq_val(int'(a[2:0]));
      return 17'(int'(a) * 13 + 1000);
   endfunction

   always @(posedge clk_40k) rom_rdata <= rom_word(rom_addr);

   // Behavioural biquad load port: first delayed strobe is the lead-in, then 6 words
   logic               bq_en_d;
   int                 bq_cnt;
   logic signed [16:0] bq_buf  [6];
   logic signed [16:0] bq_coef [6];

   always @(posedge clk_40k) begin
      if (rst) begin
         bq_en_d <= 1'b0;
         bq_cnt  <= 0;
      end else begin
         bq_en_d <= coe_en[0];
         if (bq_en_d) begin
            if (bq_cnt >= 1 && bq_cnt <= 6) bq_buf[bq_cnt-1] <= coe;
            bq_cnt <= bq_cnt + 1;
         end else if (bq_cnt != 0) begin
            bq_coef <= bq_buf;
            bq_cnt  <= 0;
         end
      end
   end

   typedef struct {
      logic [1:0] band;
      logic [4:0] gain;
      bit         pitch;
   } frame_t;

   frame_t sb[$];
   frame_t cur;
   bit     in_frame  = 1'b0;
   int     f         = 0;
   int     start_cyc = 0;

   always @(negedge clk_40k) begin
      if (rst) begin
         in_frame = 1'b0;
      end else begin
         if (!in_frame && busy) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_frame: busy=%0b coe_en=%b with no frame expected (cycle %0d)",
                        busy, coe_en, cyc);
               in_frame = 1'b1;
               cur.band = 2'd0;
               cur.gain = 5'd0;
               cur.pitch = 1'b0;
               f = 0;
            end else begin
               cur = sb.pop_front();
               in_frame = 1'b1;
               f = 0;
               if (cur.pitch) chk("frame_pitch", 32'(cyc - start_cyc), 32'd10);
               start_cyc = cyc;
            end
         end
         if (in_frame) begin
            chk("coe_en", 32'(coe_en), (f <= 6) ? 32'(4'b0001 << cur.band) : 32'd0);
            if (f <= 5) chk("rom_addr", 32'(rom_addr), 32'({cur.band, cur.gain, 3'(f)}));
            if (f >= 2 && f <= 7)
               chk("coe", 32'(coe), 32'(rom_word({cur.band, cur.gain, 3'(f - 2)})));
            chk("busy", 32'(busy), 32'd1);
            chk("done", 32'(done), 32'(f == 8));
            if (f == 8) chk("done_band", 32'(done_band), 32'(cur.band));
            f++;
            if (f == 10) in_frame = 1'b0;
         end else begin
            chk("idle_coe_en", 32'(coe_en), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
         end
      end
   end

   task automatic pulse_req(input logic [1:0] b, input logic [4:0] g);
      req = 1'b1;
      req_band = b;
      req_gain = g;
      @(posedge clk_40k);
      #1;
      req = 1'b0;
   endtask

   task automatic expect_frame(input logic [1:0] b, input logic [4:0] g, input bit p);
      frame_t e;
      e.band = b;
      e.gain = g;
      e.pitch = p;
      sb.push_back(e);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_40k);
         #1;
      end
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((busy || sb.size() != 0 || in_frame) && n < budget) begin
         @(posedge clk_40k);
         #1;
         n++;
      end
      chk("wait_idle_in_budget", 32'(n < budget), 32'd1);
      idle_cycles(2);
      chk("busy_after_frames", 32'(busy), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_coe"},       32'(coe),       32'd0);
      chk({tag, "_coe_en"},    32'(coe_en),    32'd0);
      chk({tag, "_rom_addr"},  32'(rom_addr),  32'd0);
      chk({tag, "_busy"},      32'(busy),      32'd0);
      chk({tag, "_done"},      32'(done),      32'd0);
      chk({tag, "_done_band"}, 32'(done_band), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      idle_cycles(3);
      rst = 1'b0;
      chk_reset_outputs("reset");

      // load_all from reset: bands 0..3 back-to-back at DEF_GAIN
      expect_frame(2'd0, 5'd12, 1'b0);
      expect_frame(2'd1, 5'd12, 1'b1);
      expect_frame(2'd2, 5'd12, 1'b1);
      expect_frame(2'd3, 5'd12, 1'b1);
      load_all = 1'b1;
      @(posedge clk_40k);
      #1;
      load_all = 1'b0;
      wait_idle(80);

      // single request
      expect_frame(2'd1, 5'd20, 1'b0);
      pulse_req(2'd1, 5'd20);
      chk("grant_next_cycle_busy", 32'(busy), 32'd1);
      wait_idle(30);

      // band 2 re-requested before its grant: one frame, latest gain
      expect_frame(2'd1, 5'd0, 1'b0);
      expect_frame(2'd2, 5'd7, 1'b1);
      pulse_req(2'd1, 5'd0);
      idle_cycles(2);
      pulse_req(2'd2, 5'd3);
      pulse_req(2'd2, 5'd7);
      wait_idle(40);

      // re-request of the loading band plus another band: rr order 3 then 0
      expect_frame(2'd0, 5'd11, 1'b0);
      expect_frame(2'd3, 5'd9, 1'b1);
      expect_frame(2'd0, 5'd5, 1'b1);
      pulse_req(2'd0, 5'd11);
      pulse_req(2'd0, 5'd5);
      pulse_req(2'd3, 5'd9);
      wait_idle(50);

      // reset at frame cycle 4 aborts the frame
      expect_frame(2'd0, 5'd2, 1'b0);
      pulse_req(2'd0, 5'd2);
      idle_cycles(4);
      rst = 1'b1;
      @(posedge clk_40k);
      #1;
      rst = 1'b0;
      chk_reset_outputs("abort");
      chk("abort_sb_consumed", 32'(sb.size()), 32'd0);
      idle_cycles(12);
      chk("abort_no_restart", 32'(busy), 32'd0);
      expect_frame(2'd0, 5'd1, 1'b0);
      pulse_req(2'd0, 5'd1);
      wait_idle(30);

      // biquad-in-loop load on band 0
      expect_frame(2'd0, 5'd31, 1'b0);
      pulse_req(2'd0, 5'd31);
      wait_idle(30);
      for (int i = 0; i < 6; i++) chk($sformatf("bq_coef%0d", i), 32'(bq_coef[i]), 32'(bq_val(i)));
      chk("bq_load_cnt", 32'(bq_cnt), 32'd0);

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
